lsp_az_combine: RTL

- Reads the F1/F2 sum/difference polynomial arrays that get_lsp_pol writes into scratch memory, and produces the 11 LPC coefficients a[0..10] (G.729 Lsp_Az back half).
- Step 1, merge: f1[i] += f1[i-1] and f2[i] -= f2[i-1], for i = 5..1.
- Step 2, combine: a[i] and a[11-i] from rounded f1 ± f2.
- Sits in Encoder/Int_LPC after both get_lsp_pol runs; results go to scratch memory.

---
 rtl/lsp_az_combine_pkg.sv | 27 ++
 rtl/lsp_az_combine_if.sv | 27 ++
 rtl/lsp_az_combine_sat.sv | 27 ++
 rtl/lsp_az_combine.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/lsp_az_combine_pkg.sv
// rtl/lsp_az_combine_pkg.sv - shared constants and state encoding for lsp_az_combine
package lsp_az_combine_pkg;

    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_A0_VALUE  = 4096;
    localparam int DEF_RND_SHIFT = 13;

    // Default scratch-memory layout used by Int_LPC for the polynomial and LPC arrays
    localparam logic [11:0] F1_BASE = 12'h100;
    localparam logic [11:0] F2_BASE = 12'h200;
    localparam logic [11:0] A_BASE  = 12'h300;

    typedef enum logic [3:0] {
        S_IDLE,
        S_M_RD_HI,
        S_M_RD_LO,
        S_M_WR,
        S_A0,
        S_C_RD1,
        S_C_RD2,
        S_C_WR1,
        S_C_WR2,
        S_DONE
    } state_t;

endpackage

// File: rtl/lsp_az_combine_if.sv
// rtl/lsp_az_combine_if.sv - scratch-memory port bundle (one read port, one write port)
interface lsp_az_combine_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] scratch_mem_read_addr;
    logic [DATA_W-1:0] scratch_mem_in;
    logic [ADDR_W-1:0] scratch_mem_write_addr;
    logic [DATA_W-1:0] scratch_mem_out;
    logic              scratch_mem_write_en;

    modport master (
        output scratch_mem_read_addr,
        input  scratch_mem_in,
        output scratch_mem_write_addr,
        output scratch_mem_out,
        output scratch_mem_write_en
    );

    modport slave (
        input  scratch_mem_read_addr,
        output scratch_mem_in,
        input  scratch_mem_write_addr,
        input  scratch_mem_out,
        input  scratch_mem_write_en
    );
endinterface

// File: rtl/lsp_az_combine_sat.sv
// rtl/lsp_az_combine_sat.sv - combinational saturating 32-bit add/sub (L_add / L_sub)
module sat_addsub32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_y,
    output logic         o_ovf
);
    logic [W:0] w_a_ext;
    logic [W:0] w_b_ext;
    logic [W:0] w_r;

    // One guard bit: the true result overflowed when the top two bits disagree
    always_comb begin
        w_a_ext = {i_a[W-1], i_a};
        w_b_ext = {i_b[W-1], i_b};
        w_r     = i_sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
        o_ovf   = w_r[W] ^ w_r[W-1];
        if (o_ovf) begin
            o_y = w_r[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            o_y = w_r[W-1:0];
        end
    end
endmodule

// File: rtl/lsp_az_combine.sv
// rtl/lsp_az_combine.sv - G.729 Lsp_Az back half: merge F1/F2 and combine into a[0..10]
module lsp_az_combine
    import lsp_az_combine_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int A0_VALUE  = DEF_A0_VALUE,
    parameter int RND_SHIFT = DEF_RND_SHIFT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] f1_addr,
    input  logic [ADDR_W-1:0] f2_addr,
    input  logic [ADDR_W-1:0] a_addr,
    lsp_az_combine_if.master  mem,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_i;
    logic              r_sel;
    logic [DATA_W-1:0] r_t_hi;
    logic [DATA_W-1:0] r_t_f1;
    logic [DATA_W-1:0] r_t_f2;
    logic              r_ovf;

    logic [ADDR_W-1:0] w_i;
    logic [ADDR_W-1:0] w_f_base;
    logic [DATA_W-1:0] w_mrg_y;
    logic              w_mrg_ovf;
    logic [DATA_W-1:0] w_cmb_b;
    logic [DATA_W-1:0] w_cmb_y;
    logic              w_cmb_ovf;
    logic [15:0]       w_rnd16;
    logic [DATA_W-1:0] w_a_word;
    logic              w_rnd_unused;

    assign w_i      = ADDR_W'(r_i);
    assign w_f_base = r_sel ? f2_addr : f1_addr;
    assign overflow = r_ovf;

    sat_addsub32 #(.W(DATA_W)) u_merge (
        .i_a   (r_t_hi),
        .i_b   (mem.scratch_mem_in),
        .i_sub (r_sel),
        .o_y   (w_mrg_y),
        .o_ovf (w_mrg_ovf)
    );

    // C_WR1 forms f1+f2 straight from the returning read; C_WR2 reuses the latched f2
    assign w_cmb_b = (r_state == S_C_WR2) ? r_t_f2 : mem.scratch_mem_in;

    sat_addsub32 #(.W(DATA_W)) u_combine (
        .i_a   (r_t_f1),
        .i_b   (w_cmb_b),
        .i_sub (r_state == S_C_WR2),
        .o_y   (w_cmb_y),
        .o_ovf (w_cmb_ovf)
    );

    // L_shr_r then extract_l: only 16 bits above the shift point survive
    assign w_rnd16      = w_cmb_y[RND_SHIFT +: 16] + {15'd0, w_cmb_y[RND_SHIFT-1]};
    assign w_a_word     = {{(DATA_W-16){w_rnd16[15]}}, w_rnd16};
    assign w_rnd_unused = ^{w_cmb_y[DATA_W-1:RND_SHIFT+16], w_cmb_y[RND_SHIFT-2:0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next                     = r_state;
        mem.scratch_mem_read_addr  = '0;
        mem.scratch_mem_write_addr = '0;
        mem.scratch_mem_out        = '0;
        mem.scratch_mem_write_en   = 1'b0;
        busy                       = (r_state != S_IDLE);
        done                       = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_M_RD_HI;
            S_M_RD_HI: begin
                mem.scratch_mem_read_addr = w_f_base + w_i;
                w_next = S_M_RD_LO;
            end
            S_M_RD_LO: begin
                mem.scratch_mem_read_addr = w_f_base + w_i - ADDR_W'(1);
                w_next = S_M_WR;
            end
            S_M_WR: begin
                mem.scratch_mem_write_addr = w_f_base + w_i;
                mem.scratch_mem_out        = w_mrg_y;
                mem.scratch_mem_write_en   = 1'b1;
                w_next = (r_sel && r_i == 3'd1) ? S_A0 : S_M_RD_HI;
            end
            S_A0: begin
                mem.scratch_mem_write_addr = a_addr;
                mem.scratch_mem_out        = DATA_W'(A0_VALUE);
                mem.scratch_mem_write_en   = 1'b1;
                w_next = S_C_RD1;
            end
            S_C_RD1: begin
                mem.scratch_mem_read_addr = f1_addr + w_i;
                w_next = S_C_RD2;
            end
            S_C_RD2: begin
                mem.scratch_mem_read_addr = f2_addr + w_i;
                w_next = S_C_WR1;
            end
            S_C_WR1: begin
                mem.scratch_mem_write_addr = a_addr + w_i;
                mem.scratch_mem_out        = w_a_word;
                mem.scratch_mem_write_en   = 1'b1;
                w_next = S_C_WR2;
            end
            S_C_WR2: begin
                mem.scratch_mem_write_addr = a_addr + ADDR_W'(4'd11 - {1'b0, r_i});
                mem.scratch_mem_out        = w_a_word;
                mem.scratch_mem_write_en   = 1'b1;
                w_next = (r_i == 3'd5) ? S_DONE : S_C_RD1;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_i    <= '0;
            r_sel  <= 1'b0;
            r_t_hi <= '0;
            r_t_f1 <= '0;
            r_t_f2 <= '0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_ovf <= 1'b0;
                    r_i   <= 3'd5;
                    r_sel <= 1'b0;
                end
                S_M_RD_LO: r_t_hi <= mem.scratch_mem_in;
                S_M_WR: begin
                    if (w_mrg_ovf) r_ovf <= 1'b1;
                    r_sel <= ~r_sel;
                    if (r_sel) r_i <= r_i - 3'd1;
                end
                S_A0:    r_i    <= 3'd1;
                S_C_RD2: r_t_f1 <= mem.scratch_mem_in;
                S_C_WR1: begin
                    r_t_f2 <= mem.scratch_mem_in;
                    if (w_cmb_ovf) r_ovf <= 1'b1;
                end
                S_C_WR2: begin
                    if (w_cmb_ovf) r_ovf <= 1'b1;
                    if (r_i != 3'd5) r_i <= r_i + 3'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
